// File: rtl/univ_ff_bank.sv
// WIDTH-bit flip-flop bank with per-cycle JK/D/T/SR mode, parallel load, enable,
// change flag and SR-illegal detection. Define UNIV_FF_CHANGE_CNT_EN for a saturating change counter.

module univ_ff_lane (
  input  logic [1:0] mode,
  input  logic       q,
  input  logic       a,
  input  logic       b,
  output logic       q_nxt,
  output logic       illegal
);
  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    unique case (mode)
      2'b00: begin
        unique case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   q_nxt = ~q;
          default: q_nxt = q;
        endcase
      end
      2'b01: q_nxt = a;
      2'b10: q_nxt = a ? ~q : q;
      default: begin
        // S=R=1 is flagged and the bit keeps its state
        unique case ({a, b})
          2'b01:   q_nxt = 1'b0;
          2'b10:   q_nxt = 1'b1;
          2'b11:   illegal = 1'b1;
          default: q_nxt = q;
        endcase
      end
    endcase
  end
endmodule

module univ_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
`ifdef UNIV_FF_CHANGE_CNT_EN
  ,
  parameter int               CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             changed,
  output logic             sr_err
`ifdef UNIV_FF_CHANGE_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] change_cnt
`endif
);
  logic [WIDTH-1:0] q_r, upd, ill, q_next;
  logic             sr_hit, diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    univ_ff_lane u_lane (
      .mode    (mode),
      .q       (q_r[i]),
      .a       (a[i]),
      .b       (b[i]),
      .q_nxt   (upd[i]),
      .illegal (ill[i])
    );
  end

  always_comb begin
    q_next = q_r;
    sr_hit = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = upd;
      sr_hit = |ill;
    end
  end

  assign diff = (q_next != q_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r     <= RESET_VAL;
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      q_r     <= q_next;
      changed <= diff;
      sr_err  <= sr_hit;
    end
  end

`ifdef UNIV_FF_CHANGE_CNT_EN
  logic [CNT_W-1:0] cnt_r;
  always_ff @(posedge clk) begin
    if (!rst)                              cnt_r <= '0;
    else if (cnt_clr)                      cnt_r <= '0;
    else if (diff && (cnt_r != {CNT_W{1'b1}})) cnt_r <= cnt_r + 1'b1;
  end
  assign change_cnt = cnt_r;
`endif

  assign q  = q_r;
  assign qn = ~q_r;
endmodule
